// File: rtl/ecc_pkg.sv
// Shared SECDED(39,32) definitions for the memory stage: widths, scrub FSM
// states and the Hamming encoder used on the store path.
package ecc_pkg;

  localparam int CW_W   = 39;
  localparam int DATA_W = 32;

  typedef enum logic {IDLE, SCRUB} state_t;

  // Position p (1..38) lives at bit p-1; powers of two are check bits,
  // bit 38 is even parity over bits 0..37.
  function automatic logic [CW_W-1:0] secded_encode(input logic [DATA_W-1:0] data);
    logic [CW_W-1:0] cw;
    logic            par;
    int              d;
    cw = '0;
    d  = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p-1] = data[d];
        d++;
      end
    end
    for (int k = 0; k < 6; k++) begin
      par = 1'b0;
      for (int p = 1; p <= 38; p++) begin
        if (p[k] && (p != (1 << k))) par = par ^ cw[p-1];
      end
      cw[(1 << k) - 1] = par;
    end
    cw[38] = ^cw[37:0];
    return cw;
  endfunction

endpackage

// File: rtl/secded_decode.sv
// Combinational SECDED(39,32) decoder: syndrome, overall parity, single-bit
// correction and double-error detection.
module secded_decode
  import ecc_pkg::*;
(
  input  logic [CW_W-1:0]   cw,
  output logic [DATA_W-1:0] data,
  output logic              sec,
  output logic              ded,
  output logic [CW_W-1:0]   cw_fix
);

  logic [5:0] syn;
  logic       par;
  int         d;

  always_comb begin
    syn    = '0;
    par    = ^cw;
    sec    = 1'b0;
    ded    = 1'b0;
    cw_fix = cw;
    data   = '0;
    d      = 0;
    for (int k = 0; k < 6; k++) begin
      for (int p = 1; p <= 38; p++) begin
        if (p[k]) syn[k] = syn[k] ^ cw[p-1];
      end
    end
    if (par) begin
      if (syn == 6'd0) begin
        sec        = 1'b1;
        cw_fix[38] = ~cw[38];
      end else if (syn <= 6'd38) begin
        sec = 1'b1;
        for (int p = 1; p <= 38; p++) begin
          if (syn == p[5:0]) cw_fix[p-1] = ~cw[p-1];
        end
      end else begin
        ded = 1'b1;
      end
    end else if (syn != 6'd0) begin
      ded = 1'b1;
    end
    // On DED cw_fix is the raw word, so the data returned is uncorrected
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        data[d] = cw_fix[p-1];
        d++;
      end
    end
  end

endmodule

// File: rtl/memory_cycle_ecc.sv
// RV32 memory stage with SECDED-protected data memory, one-cycle scrub of
// corrected loads, and MEM/WB pipeline register.
module memory_cycle_ecc
  import ecc_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] PCPlus4M,
  input  logic [31:0] WriteDataM,
  input  logic [31:0] ALU_ResultM,
  input  logic        InjEn,
  input  logic [38:0] InjMask,
  input  logic        ClrErr,
  output logic        RegWriteW,
  output logic        ResultSrcW,
  output logic [4:0]  RD_W,
  output logic [31:0] PCPlus4W,
  output logic [31:0] ALU_ResultW,
  output logic [31:0] ReadDataW,
  output logic        StallM,
  output logic [15:0] SecCount,
  output logic        DedFlag,
  output logic [31:0] DedAddr
);

  logic [CW_W-1:0]   mem [DEPTH];
  logic [AW-1:0]     addr;
  logic [CW_W-1:0]   rd_cw;
  logic [DATA_W-1:0] rd_data;
  logic              rd_sec;
  logic              rd_ded;
  logic [CW_W-1:0]   rd_fix;
  logic [CW_W-1:0]   scrub_cw;
  logic [AW-1:0]     scrub_addr;
  state_t            state;
  state_t            next_state;
  logic              is_load;
  logic              sec_evt;
  logic              ded_evt;

  assign addr  = ALU_ResultM[AW+1:2];
  assign rd_cw = mem[addr];

  secded_decode u_dec (
    .cw     (rd_cw),
    .data   (rd_data),
    .sec    (rd_sec),
    .ded    (rd_ded),
    .cw_fix (rd_fix)
  );

  always_comb begin
    is_load    = ResultSrcM & ~MemWriteM;
    sec_evt    = 1'b0;
    ded_evt    = 1'b0;
    StallM     = 1'b0;
    next_state = state;
    case (state)
      IDLE: begin
        sec_evt = is_load & rd_sec;
        ded_evt = is_load & rd_ded;
        if (sec_evt) next_state = SCRUB;
      end
      SCRUB: begin
        StallM     = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Array is never reset; reset forces IDLE asynchronously, so an
  // interrupted scrub simply never writes.
  always_ff @(posedge clk) begin
    if (state == SCRUB)
      mem[scrub_addr] <= scrub_cw;
    else if (MemWriteM)
      mem[addr] <= secded_encode(WriteDataM) ^ (InjEn ? InjMask : '0);
  end

  always_ff @(posedge clk) begin
    if (sec_evt) begin
      scrub_cw   <= rd_fix;
      scrub_addr <= addr;
    end
  end

  // ---- MEM/WB register boundary ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else if (state == SCRUB) begin
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 1'b0;
      RD_W        <= '0;
      PCPlus4W    <= '0;
      ALU_ResultW <= '0;
      ReadDataW   <= '0;
    end else begin
      RegWriteW   <= RegWriteM & ~ded_evt;
      ResultSrcW  <= ResultSrcM;
      RD_W        <= RD_M;
      PCPlus4W    <= PCPlus4M;
      ALU_ResultW <= ALU_ResultM;
      ReadDataW   <= rd_data;
    end
  end

  // A new event in the same cycle as ClrErr takes precedence over the clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      SecCount <= '0;
      DedFlag  <= 1'b0;
      DedAddr  <= '0;
    end else begin
      if (sec_evt)
        SecCount <= ClrErr ? 16'd1 : ((SecCount == 16'hFFFF) ? SecCount : SecCount + 16'd1);
      else if (ClrErr)
        SecCount <= '0;
      if (ded_evt)
        DedFlag <= 1'b1;
      else if (ClrErr)
        DedFlag <= 1'b0;
      if (ded_evt)
        DedAddr <= ALU_ResultM;
    end
  end

endmodule

// File: tb/tb_memory_cycle_ecc.sv
// Directed bench for memory_cycle_ecc: stores, loads, injected single and
// double errors, scrub stall, error-status clearing and reset during scrub.
module tb_memory_cycle_ecc;

  logic        clk = 1'b0;
  logic        rst;
  logic        RegWriteM, MemWriteM, ResultSrcM;
  logic [4:0]  RD_M;
  logic [31:0] PCPlus4M, WriteDataM, ALU_ResultM;
  logic        InjEn;
  logic [38:0] InjMask;
  logic        ClrErr;
  logic        RegWriteW, ResultSrcW;
  logic [4:0]  RD_W;
  logic [31:0] PCPlus4W, ALU_ResultW, ReadDataW;
  logic        StallM;
  logic [15:0] SecCount;
  logic        DedFlag;
  logic [31:0] DedAddr;

  int n_cmp = 0;
  int n_bad = 0;

  memory_cycle_ecc #(.DEPTH(256)) dut (
    .clk         (clk),
    .rst         (rst),
    .RegWriteM   (RegWriteM),
    .MemWriteM   (MemWriteM),
    .ResultSrcM  (ResultSrcM),
    .RD_M        (RD_M),
    .PCPlus4M    (PCPlus4M),
    .WriteDataM  (WriteDataM),
    .ALU_ResultM (ALU_ResultM),
    .InjEn       (InjEn),
    .InjMask     (InjMask),
    .ClrErr      (ClrErr),
    .RegWriteW   (RegWriteW),
    .ResultSrcW  (ResultSrcW),
    .RD_W        (RD_W),
    .PCPlus4W    (PCPlus4W),
    .ALU_ResultW (ALU_ResultW),
    .ReadDataW   (ReadDataW),
    .StallM      (StallM),
    .SecCount    (SecCount),
    .DedFlag     (DedFlag),
    .DedAddr     (DedAddr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic ld, input logic rw, input logic [4:0] rd,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [38:0] mask, input logic clr);
    MemWriteM   = we;
    ResultSrcM  = ld;
    RegWriteM   = rw;
    RD_M        = rd;
    ALU_ResultM = a;
    WriteDataM  = wd;
    PCPlus4M    = a + 32'h100;
    InjEn       = (mask != '0);
    InjMask     = mask;
    ClrErr      = clr;
  endtask

  task automatic nop();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 39'h0, 1'b0);
  endtask

  initial begin
    rst = 1'b0;
    nop();
    #12;
    chk("rst_regwrite", {31'b0, RegWriteW}, 32'h0);
    chk("rst_readdata", ReadDataW, 32'h0);
    chk("rst_stall", {31'b0, StallM}, 32'h0);
    chk("rst_seccount", {16'b0, SecCount}, 32'h0);
    chk("rst_dedflag", {31'b0, DedFlag}, 32'h0);
    chk("rst_dedaddr", DedAddr, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;

    // Clean store / load
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h10, 32'hDEADBEEF, 39'h0, 1'b0); tick();
    chk("clean_store_stall", {31'b0, StallM}, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 5'd5, 32'h10, 32'h0, 39'h0, 1'b0); tick();
    chk("clean_data", ReadDataW, 32'hDEADBEEF);
    chk("clean_regwrite", {31'b0, RegWriteW}, 32'h1);
    chk("clean_rd", {27'b0, RD_W}, 32'd5);
    chk("clean_pc4", PCPlus4W, 32'h110);
    chk("clean_alu", ALU_ResultW, 32'h10);
    chk("clean_stall", {31'b0, StallM}, 32'h0);
    chk("clean_sec", {16'b0, SecCount}, 32'h0);

    // Single error on data bit 0 (codeword bit 2)
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h14, 32'h0, 39'h4, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 5'd6, 32'h14, 32'h0, 39'h0, 1'b0); tick();
    chk("sec_d0_data", ReadDataW, 32'h0);
    chk("sec_d0_count", {16'b0, SecCount}, 32'h1);
    chk("sec_d0_stall", {31'b0, StallM}, 32'h1);
    nop(); tick();
    chk("sec_d0_stall_end", {31'b0, StallM}, 32'h0);
    chk("bubble_regwrite", {31'b0, RegWriteW}, 32'h0);
    chk("bubble_resultsrc", {31'b0, ResultSrcW}, 32'h0);
    chk("bubble_rd", {27'b0, RD_W}, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 5'd6, 32'h14, 32'h0, 39'h0, 1'b0); tick();
    chk("reload_data", ReadDataW, 32'h0);
    chk("reload_stall", {31'b0, StallM}, 32'h0);
    chk("reload_count", {16'b0, SecCount}, 32'h1);

    // Overall-parity bit error; ClrErr rides along with the store
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h18, 32'h12345678, 39'h40_0000_0000, 1'b1); tick();
    chk("clr_count", {16'b0, SecCount}, 32'h0);
    drive(1'b0, 1'b1, 1'b1, 5'd7, 32'h18, 32'h0, 39'h0, 1'b0); tick();
    chk("sec_p_data", ReadDataW, 32'h12345678);
    chk("sec_p_count", {16'b0, SecCount}, 32'h1);
    chk("sec_p_stall", {31'b0, StallM}, 32'h1);
    nop(); tick();
    chk("sec_p_stall_end", {31'b0, StallM}, 32'h0);

    // Double error at positions 1 and 6 (data bit 2 corrupted in raw data)
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h20, 32'hCAFEF00D, 39'h21, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 5'd8, 32'h20, 32'h0, 39'h0, 1'b0); tick();
    chk("ded_flag", {31'b0, DedFlag}, 32'h1);
    chk("ded_addr", DedAddr, 32'h20);
    chk("ded_regwrite", {31'b0, RegWriteW}, 32'h0);
    chk("ded_raw_data", ReadDataW, 32'hCAFEF009);
    chk("ded_count", {16'b0, SecCount}, 32'h1);
    chk("ded_stall", {31'b0, StallM}, 32'h0);

    // DED with ClrErr in the same cycle, then ClrErr alone
    drive(1'b0, 1'b1, 1'b1, 5'd8, 32'h20, 32'h0, 39'h0, 1'b1); tick();
    chk("ded_clr_flag", {31'b0, DedFlag}, 32'h1);
    chk("ded_clr_count", {16'b0, SecCount}, 32'h0);
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0, 39'h0, 1'b1); tick();
    chk("clr_flag", {31'b0, DedFlag}, 32'h0);
    chk("clr_count2", {16'b0, SecCount}, 32'h0);
    chk("clr_dedaddr_kept", DedAddr, 32'h20);

    // SEC together with ClrErr: counter lands at 1
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h24, 32'h0, 39'h400, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 5'd9, 32'h24, 32'h0, 39'h0, 1'b0); tick();
    nop(); tick();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h24, 32'h0, 39'h800, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 5'd9, 32'h24, 32'h0, 39'h0, 1'b1); tick();
    chk("sec_clr_count", {16'b0, SecCount}, 32'h1);
    nop(); tick();

    // Store to the scrubbed address held across SCRUB must survive the scrub
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h28, 32'hA5A5A5A5, 39'h4, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 5'd10, 32'h28, 32'h0, 39'h0, 1'b0); tick();
    chk("hold_stall", {31'b0, StallM}, 32'h1);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h28, 32'h00000055, 39'h0, 1'b0); tick();
    chk("hold_stall_end", {31'b0, StallM}, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 5'd10, 32'h28, 32'h0, 39'h0, 1'b0); tick();
    chk("hold_newer_data", ReadDataW, 32'h00000055);
    chk("hold_no_stall", {31'b0, StallM}, 32'h0);
    nop(); tick();

    // Reset during SCRUB abandons the scrub
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h2C, 32'h0F0F0F0F, 39'h4, 1'b0); tick();
    drive(1'b0, 1'b1, 1'b1, 5'd11, 32'h2C, 32'h0, 39'h0, 1'b0); tick();
    chk("pre_rst_stall", {31'b0, StallM}, 32'h1);
    nop();
    rst = 1'b0;
    #1;
    chk("rst_scrub_stall", {31'b0, StallM}, 32'h0);
    chk("rst_scrub_data", ReadDataW, 32'h0);
    chk("rst_scrub_regwrite", {31'b0, RegWriteW}, 32'h0);
    chk("rst_scrub_count", {16'b0, SecCount}, 32'h0);
    tick();
    rst = 1'b1;
    tick();
    drive(1'b0, 1'b1, 1'b1, 5'd11, 32'h2C, 32'h0, 39'h0, 1'b0); tick();
    chk("rescrub_stall", {31'b0, StallM}, 32'h1);
    chk("rescrub_count", {16'b0, SecCount}, 32'h1);
    chk("rescrub_data", ReadDataW, 32'h0F0F0F0F);
    nop(); tick();
    chk("rescrub_stall_end", {31'b0, StallM}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/memory_cycle_ecc.md
# memory_cycle_ecc

Memory stage of the five-stage RV32 pipeline with a SECDED Hamming-protected data memory. Consumes the EX/MEM pipeline register fields, performs word stores (encoding 32-bit data into a 39-bit codeword) and loads (decoding, single-error correction, double-error detection), then drives the MEM/WB pipeline register. Corrected single-bit errors are scrubbed back to memory by a one-cycle stall sequence, and error status is exported to the hazard/debug logic.

## Interface
- DEPTH, 256: data memory depth in 32-bit words; power of two.
- AW, log2(DEPTH): word-address width.
- clk  in  1  pipeline clock.
- rst  in  1  asynchronous, active-low reset.
- RegWriteM, MemWriteM, ResultSrcM  in  1 each  EX/MEM control fields.
- RD_M  in  5  destination register.
- PCPlus4M, WriteDataM, ALU_ResultM  in  32 each  EX/MEM data fields; address is ALU_ResultM[AW+1:2].
- InjEn  in  1  fault injection enable, applies to the store in MEM this cycle.
- InjMask  in  39  bits XORed into the stored codeword when InjEn=1.
- ClrErr  in  1  clears SecCount and DedFlag.
- RegWriteW, ResultSrcW  out  1 each  MEM/WB control.
- RD_W  out  5; PCPlus4W, ALU_ResultW, ReadDataW  out  32 each  MEM/WB data.
- StallM  out  1  freeze IF/ID/EX and the EX/MEM register this cycle.
- SecCount  out  16  saturating count of corrected errors.
- DedFlag  out  1  sticky uncorrectable-error flag.
- DedAddr  out  32  ALU_ResultM of the most recent DED load.

## Operation
- Codeword: position p (1..38) at bit p-1; check bits at positions 1,2,4,8,16,32; data bits 0..31 fill remaining positions in ascending order; bit 38 = even parity over bits 0..37.
- Store (MemWriteM=1, state IDLE): mem[addr] <= encode(WriteDataM) ^ (InjEn ? InjMask : 0), write at clock edge.
- Load (ResultSrcM=1, MemWriteM=0): asynchronous array read; syndrome s (6 bits), overall parity P over 39 bits.
  - s=0, P=0: clean.
  - P=1, s=0: parity-bit error; data unchanged; SEC.
  - P=1, 1<=s<=38: flip position s; SEC.
  - P=1, s>38, or s!=0 with P=0: DED; ReadDataW = raw uncorrected data, RegWriteW forced 0, DedFlag <= 1, DedAddr <= ALU_ResultM.
- SEC on load: SecCount increments (saturates at 0xFFFF); corrected codeword and address latched; FSM goes to SCRUB.
- FSM IDLE: normal. SCRUB: write latched corrected codeword to latched address; StallM=1; inputs ignored; MEM/WB loads a bubble (RegWriteW=0, ResultSrcW=0, RD_W=0); next state IDLE unconditionally.
- Non-load, non-store ops pass through; ReadDataW = decoded data of the addressed word regardless (don't-care to WB).
- ClrErr same cycle as new SEC/DED: the new event wins (counter becomes 1, flag stays 1).
- Memory array is not reset; all-zero codeword is valid, so power-up-zero memory decodes clean.

## Timing
- Reset: state IDLE, all MEM/WB outputs 0, StallM 0, SecCount 0, DedFlag 0, DedAddr 0.
- MEM/WB outputs registered: one-cycle latency from EX/MEM fields.
- StallM is combinational from state (high only in SCRUB), exactly one cycle per SEC load.
- Back-to-back SEC loads: each produces its own SCRUB cycle; the second load is held by StallM and processed after scrub.
- Store to the same address in cycle after SEC load is held by SCRUB; the scrub write never overwrites newer data.
- Reset asserted in SCRUB: scrub abandoned, array unchanged.

## Structure
- Package ecc_pkg: CW_W=39, DATA_W=32, state enum {IDLE, SCRUB}, function secded_encode(data)->codeword.
- Sub-module secded_decode (combinational): codeword in; corrected data, sec, ded, corrected codeword out.
- Top holds array, FSM, MEM/WB register, error counters.

## Test plan
- Store 0xDEADBEEF to 0x10, load 0x10 -> ReadDataW=0xDEADBEEF, RegWriteW=1, StallM never high, SecCount=0.
- Store 0x00000000 to 0x14 with InjMask=bit 2 (data bit 0), load -> ReadDataW=0x00000000, SecCount=1, StallM high one cycle; reload -> no StallM, SecCount stays 1.
- Store 0x12345678 with InjMask=bit 38, load -> ReadDataW=0x12345678, SecCount=1, scrub occurs.
- Store 0xCAFEF00D to 0x20 with InjMask=bits 0 and 5, load -> DedFlag=1, DedAddr=0x20, RegWriteW=0, SecCount unchanged.
- DED load with ClrErr same cycle -> DedFlag=1; ClrErr next cycle alone -> DedFlag=0, SecCount=0.
- rst low during SCRUB -> StallM=0 and all outputs 0 immediately; reload of address -> still SEC, scrub repeats.
